// File: rtl/gpr_file_sb.sv
// x86-style GPR file (8 x 32) with AL/AH byte lanes and an issue scoreboard.
// Define GPR_BYPASS_EN to forward same-cycle writeback data to the read ports.
module gpr_file_sb #(
  parameter int NUM_RD   = 2,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*NUM_RD-1:0]   rd_sel,
  input  logic [2*NUM_RD-1:0]   rd_size,
  output logic [32*NUM_RD-1:0]  rd_data,
  output logic [NUM_RD-1:0]     rd_busy,
  input  logic                  wr_en,
  input  logic [2:0]            wr_sel,
  input  logic [1:0]            wr_size,
  input  logic [31:0]           wr_data,
  input  logic                  alloc_en,
  input  logic [2:0]            alloc_sel,
  output logic [7:0]            busy_vec
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic [2:0]          wr_phys;
  logic [DATA_W-1:0]   wr_merged;

  logic [2:0]          port_phys [NUM_RD];
  logic [DATA_W-1:0]   port_val  [NUM_RD];
  logic                port_busy [NUM_RD];

  // Byte specifiers 4-7 name the high byte of registers 0-3.
  function automatic logic [2:0] phys_idx(
    input logic [2:0] sel,
    input logic [1:0] size
  );
    if (size == SZ_BYTE && sel[2])
      phys_idx = {1'b0, sel[1:0]};
    else
      phys_idx = sel;
  endfunction

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old,
    input logic [2:0]        sel,
    input logic [1:0]        size,
    input logic [31:0]       data
  );
    lane_merge = old;
    case (size)
      SZ_BYTE: begin
        if (sel[2])
          lane_merge[15:8] = data[7:0];
        else
          lane_merge[7:0] = data[7:0];
      end
      SZ_WORD: lane_merge[15:0] = data[15:0];
      default: lane_merge = data;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(
    input logic [DATA_W-1:0] r,
    input logic [2:0]        sel,
    input logic [1:0]        size
  );
    case (size)
      SZ_BYTE: begin
        if (sel[2])
          lane_extract = {24'h0, r[15:8]};
        else
          lane_extract = {24'h0, r[7:0]};
      end
      SZ_WORD: lane_extract = {16'h0, r[15:0]};
      default: lane_extract = r;
    endcase
  endfunction

  always_comb begin
    wr_phys   = phys_idx(wr_sel, wr_size);
    wr_merged = lane_merge(regs_q[wr_phys], wr_sel, wr_size, wr_data);
  end

  // Allocation is applied after the clear so it wins on a collision.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      regs_d[r] = regs_q[r];
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[wr_phys] = wr_merged;
      busy_d[wr_phys] = 1'b0;
    end
    if (alloc_en)
      busy_d[alloc_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      port_phys[i] = phys_idx(rd_sel[3*i +: 3], rd_size[2*i +: 2]);
      port_val[i]  = regs_q[port_phys[i]];
      port_busy[i] = busy_q[port_phys[i]];
`ifdef GPR_BYPASS_EN
      if (wr_en && port_phys[i] == wr_phys) begin
        port_val[i]  = wr_merged;
        port_busy[i] = alloc_en && (alloc_sel == port_phys[i]);
      end
`endif
      // Outputs are gated so forwarding cannot leak data during reset.
      if (!rst) begin
        rd_data[32*i +: 32] = lane_extract(port_val[i], rd_sel[3*i +: 3],
                                           rd_size[2*i +: 2]);
        rd_busy[i] = port_busy[i];
      end
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed self-checking bench for gpr_file_sb (two read ports).
// Expected values are hand-derived from the register/lane semantics.
module tb_gpr_file_sb;

  logic        clk;
  logic        rst;
  logic [5:0]  rd_sel;
  logic [3:0]  rd_size;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [2:0]  alloc_sel;
  logic [7:0]  busy_vec;

  int n_checks;
  int n_errors;

  gpr_file_sb #(.NUM_RD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_sel    (rd_sel),
    .rd_size   (rd_size),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_size   (wr_size),
    .wr_data   (wr_data),
    .alloc_en  (alloc_en),
    .alloc_sel (alloc_sel),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_ports(input logic [2:0] s0, input logic [1:0] z0,
                          input logic [2:0] s1, input logic [1:0] z1);
    rd_sel  = {s1, s0};
    rd_size = {z1, z0};
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [1:0] z,
                    input logic [31:0] d);
    wr_en   = 1'b1;
    wr_sel  = s;
    wr_size = z;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    rd_sel    = '0;
    rd_size   = '0;
    wr_en     = 1'b0;
    wr_sel    = '0;
    wr_size   = '0;
    wr_data   = '0;
    alloc_en  = 1'b0;
    alloc_sel = '0;
    tick();
    tick();
    check("rst_busy_vec", {24'h0, busy_vec}, 32'h0);
    check("rst_rd0", rd_data[31:0], 32'h0);
    rst = 1'b0;
    tick();

    // ECX dword write, then dword / word / CH reads
    wr(3'd1, 2'b10, 32'h12345678);
    rd_ports(3'd1, 2'b10, 3'd1, 2'b01);
    check("ecx_dword", rd_data[31:0], 32'h12345678);
    check("cx_word", rd_data[63:32], 32'h00005678);
    rd_ports(3'd1, 2'b10, 3'd5, 2'b00);
    check("ch_byte", rd_data[63:32], 32'h00000056);
    check("cl_busy", {30'h0, rd_busy}, 32'h0);

    // EAX lane merges; write on a non-busy register leaves busy clear
    wr(3'd0, 2'b10, 32'hAABBCCDD);
    wr(3'd4, 2'b00, 32'hFFFFFF11);
    rd_ports(3'd0, 2'b10, 3'd0, 2'b00);
    check("eax_ah_merge", rd_data[31:0], 32'hAABB11DD);
    check("al_byte", rd_data[63:32], 32'h000000DD);
    wr(3'd0, 2'b01, 32'h55552222);
    rd_ports(3'd0, 2'b10, 3'd4, 2'b00);
    check("eax_word_merge", rd_data[31:0], 32'hAABB2222);
    check("ah_byte", rd_data[63:32], 32'h00000022);
    check("nonbusy_wr", {24'h0, busy_vec}, 32'h0);

    // EBX scoreboard via BL / BH
    alloc_en  = 1'b1;
    alloc_sel = 3'd3;
    tick();
    alloc_en  = 1'b0;
    rd_ports(3'd3, 2'b00, 3'd7, 2'b00);
    check("bl_bh_busy", {30'h0, rd_busy}, 32'h3);
    check("ebx_busy_vec", {24'h0, busy_vec}, 32'h08);
    wr_en   = 1'b1;
    wr_sel  = 3'd3;
    wr_size = 2'b00;
    wr_data = 32'h00000044;
    #1;
`ifdef GPR_BYPASS_EN
    check("bl_same_cycle", rd_data[31:0], 32'h00000044);
    check("bl_busy_same", {30'h0, rd_busy}, 32'h0);
`else
    check("bl_same_cycle", rd_data[31:0], 32'h0);
    check("bl_busy_same", {30'h0, rd_busy}, 32'h3);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check("ebx_cleared", {24'h0, busy_vec}, 32'h0);
    check("bl_written", rd_data[31:0], 32'h00000044);

    // alloc and writeback to EDX on the same edge
    alloc_en  = 1'b1;
    alloc_sel = 3'd2;
    wr(3'd2, 2'b10, 32'h0BADBEEF);
    alloc_en  = 1'b0;
    rd_ports(3'd2, 2'b10, 3'd2, 2'b10);
    check("edx_data", rd_data[31:0], 32'h0BADBEEF);
    check("edx_busy_wins", {24'h0, busy_vec}, 32'h04);
    check("edx_rd_busy", {30'h0, rd_busy}, 32'h3);

    // ESI same-cycle read
    wr(3'd6, 2'b10, 32'h11111111);
    rd_ports(3'd6, 2'b10, 3'd6, 2'b01);
    wr_en   = 1'b1;
    wr_sel  = 3'd6;
    wr_size = 2'b10;
    wr_data = 32'hCAFEF00D;
    #1;
`ifdef GPR_BYPASS_EN
    check("esi_bypass", rd_data[31:0], 32'hCAFEF00D);
`else
    check("esi_no_bypass", rd_data[31:0], 32'h11111111);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check("esi_after", rd_data[31:0], 32'hCAFEF00D);
    check("si_word", rd_data[63:32], 32'h0000F00D);

    // reserved size behaves as dword; word sel 5 addresses EBP
    wr(3'd7, 2'b11, 32'hDEADBEEF);
    wr(3'd5, 2'b01, 32'hFFFF1234);
    rd_ports(3'd7, 2'b11, 3'd5, 2'b01);
    check("edi_reserved", rd_data[31:0], 32'hDEADBEEF);
    check("bp_word", rd_data[63:32], 32'h00001234);

    // fill the scoreboard, re-alloc a busy register
    for (int r = 0; r < 8; r++) begin
      alloc_en  = 1'b1;
      alloc_sel = 3'(r);
      tick();
    end
    alloc_sel = 3'd1;
    tick();
    alloc_en = 1'b0;
    #1;
    check("busy_all", {24'h0, busy_vec}, 32'hFF);

    // asynchronous reset mid-cycle while clk is high
    rd_ports(3'd0, 2'b10, 3'd6, 2'b10);
    #1;
    rst = 1'b1;
    #1;
    check("async_busy_vec", {24'h0, busy_vec}, 32'h0);
    check("async_rd_busy", {30'h0, rd_busy}, 32'h0);
    check("async_rd0", rd_data[31:0], 32'h0);
    check("async_rd1", rd_data[63:32], 32'h0);

    // traffic during reset is discarded
    wr_en     = 1'b1;
    wr_sel    = 3'd0;
    wr_size   = 2'b10;
    wr_data   = 32'h00000099;
    alloc_en  = 1'b1;
    alloc_sel = 3'd5;
    tick();
    wr_en    = 1'b0;
    alloc_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_wr_discard", rd_data[31:0], 32'h0);
    check("rst_alloc_discard", {24'h0, busy_vec}, 32'h0);

    tick();
    wr(3'd0, 2'b10, 32'h00000077);
    #1;
    check("resume_wr", rd_data[31:0], 32'h00000077);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpr_file_sb.md
GPR_FILE_SB -- requirements
Module: gpr_file_sb

Interface
REQ-001 Parameter NUM_RD, default 2: number of read ports (1..4).
REQ-002 Parameter DATA_W, default 32: register width; fixed at 32 (x86 GPR size).
REQ-003 Parameter NUM_REGS, default 8: register count; fixed at 8; index order EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 rd_sel  input  3*NUM_RD  per-port register specifier.
REQ-007 rd_size  input  2*NUM_RD  per-port size: 00 byte, 01 word, 10 dword, 11 reserved (treated as dword).
REQ-008 rd_data  output  32*NUM_RD  per-port read data, zero-extended.
REQ-009 rd_busy  output  NUM_RD  per-port flag: the selected register has a pending write.
REQ-010 wr_en  input  1  writeback strobe.
REQ-011 wr_sel  input  3  writeback specifier.
REQ-012 wr_size  input  2  writeback size, same encoding as rd_size.
REQ-013 wr_data  input  32  writeback data; the low 8, 16 or 32 bits are used.
REQ-014 alloc_en  input  1  marks a destination as pending (issue).
REQ-015 alloc_sel  input  3  physical register index (0-7) to mark pending.
REQ-016 busy_vec  output  8  scoreboard bit per physical register.

Function
REQ-017 Byte size, specifier 0-3: selects bits [7:0] of registers 0-3 (AL, CL, DL, BL).
REQ-018 Byte size, specifier 4-7: selects bits [15:8] of registers 0-3 (AH, CH, DH, BH).
REQ-019 Word and dword sizes: the specifier addresses the register directly and selects bits [15:0] or [31:0].
REQ-020 Reads are combinational from the register array; the unselected upper bits of rd_data are driven 0.
REQ-021 Write on the rising edge with wr_en=1: only the addressed byte or word lane is updated; all other bits of the register are unchanged.
REQ-022 Physical register index for busy and alloc purposes: a byte specifier 4-7 maps to register specifier-4; all other cases map to the specifier itself.
REQ-023 Scoreboard set: alloc_en=1 sets busy_vec[alloc_sel] on the rising edge.
REQ-024 Scoreboard clear: wr_en=1 clears busy_vec at the physical register of wr_sel on the rising edge.
REQ-025 Same edge, same register, both alloc_en and wr_en asserted: the data is written and the busy bit ends set (allocation wins).
REQ-026 alloc_en on an already busy register: the bit stays set; no count is kept.
REQ-027 wr_en on a non-busy register: the data is written and the busy bit stays clear.
REQ-028 rd_busy[i] equals busy_vec at the physical index of port i, combinationally.
REQ-029 Latency: a write is visible on rd_data the cycle after the edge (without bypass); a busy-bit change is visible the cycle after the edge.

Reset
REQ-030 While rst=1: all registers hold 0, busy_vec=0, all rd_busy=0, and rd_data=0 regardless of clk.
REQ-031 A write or alloc coincident with rst is discarded; normal operation resumes on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro GPR_BYPASS_EN defined: when wr_en=1 and the physical register of port i matches that of wr_sel, rd_data[i] returns the post-merge value of the register in the same cycle, and rd_busy[i] is forced 0 for that cycle unless alloc_en also targets the same register.
REQ-033 Macro GPR_BYPASS_EN undefined: no forwarding; reads return the pre-edge register contents and the pre-edge busy bit.

Verification
REQ-034 Reset then dword write ECX=0x12345678; next cycle read ECX dword -> 0x12345678, word CX -> 0x00005678, byte CH (sel 5) -> 0x00000056.
REQ-035 EAX=0xAABBCCDD, byte write sel 4 (AH) with data 0x11 -> EAX=0xAABB11DD; then word write sel 0 with 0x2222 -> EAX=0xAABB2222.
REQ-036 alloc EBX; next cycle read BL (sel 3) and BH (sel 7) -> both rd_busy=1, busy_vec=0x08; wr_en to BL -> busy_vec=0x00 next cycle.
REQ-037 alloc_en and wr_en to EDX on the same edge -> EDX data updated and busy_vec[2]=1 afterwards.
REQ-038 Write ESI=0xCAFEF00D while port 0 reads ESI in the same cycle -> rd_data=0xCAFEF00D with GPR_BYPASS_EN, old value without it.
REQ-039 Assert rst mid-run with busy_vec=0xFF and nonzero registers -> immediately all outputs 0, independent of clk.
